param_universal_shift_register: RTL and testbench

Parametrised successor to the team's 4-bit universal shift register. It is a WIDTH-bit register with eight operating modes: hold, logical shift both directions, rotate both directions, arithmetic shift right, parallel load and clear. It adds a burst engine that repeats one shift or rotate operation for a programmed number of cycles, with `busy`/`done` status. It sits on serial/parallel conversion paths and feeds bit-serial datapaths that need multi-bit shifts without per-cycle control from the master.

---
 rtl/usr_pkg.sv | 106 ++++++++++
 rtl/usr_burst_ctrl.sv | 95 +++++++++
 rtl/param_universal_shift_register.sv | 79 +++++++
 tb/tb_param_universal_shift_register.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : usr_pkg                                                        |
// | Purpose : Shared types and helpers for param_universal_shift_register.   |
// |           - usr_op_t    : the eight operation codes carried on ctrl      |
// |           - usr_state_t : burst engine states                            |
// |           - usr_burst_ok: which ops may be repeated as a burst           |
// |           - usr_next    : next register value for one operation step     |
// | Ports   : none (package)                                                 |
// | Rev     : 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
package usr_pkg;

  // Widest register usr_next can handle. Callers zero-extend their operands
  // to this width and truncate the result back to their own WIDTH.
  localparam int USR_MAX_W = 64;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } usr_op_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_t;

  // Only ops that move bits are worth repeating; hold, load and clear
  // would give the same result after one step.
  function automatic logic usr_burst_ok(input usr_op_t op);
    logic ok;
    case (op)
      OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Next register value after one step of 'op' on a register whose live
  // width is 'width' (2..USR_MAX_W). Bits at and above 'width' come back 0
  // provided the inputs were zero-extended. 'width' is a constant at every
  // call site, so the loops collapse to plain wiring in synthesis.
  function automatic logic [USR_MAX_W-1:0] usr_next(
    input usr_op_t              op,
    input logic [USR_MAX_W-1:0] value,
    input logic                 sil,
    input logic                 sir,
    input logic [USR_MAX_W-1:0] load_value,
    input int                   width
  );
    logic [USR_MAX_W-1:0] nxt;
    logic [USR_MAX_W-1:0] shifted_dn;  // value moved one place toward bit 0
    logic [USR_MAX_W-1:0] shifted_up;  // value moved one place toward the MSB
    logic [USR_MAX_W-1:0] top_bit;     // one-hot mask of the live MSB
    logic                 msb;
    logic                 lsb;

    lsb        = value[0];
    msb        = 1'b0;
    top_bit    = '0;
    shifted_dn = '0;
    shifted_up = '0;

    for (int i = 0; i < USR_MAX_W; i++) begin
      if (i == width - 1) begin
        msb        = value[i];
        top_bit[i] = 1'b1;
      end
    end

    for (int i = 0; i < USR_MAX_W - 1; i++) begin
      if (i < width - 1) shifted_dn[i] = value[i+1];
    end

    for (int i = 1; i < USR_MAX_W; i++) begin
      if (i < width) shifted_up[i] = value[i-1];
    end

    case (op)
      OP_HOLD: nxt = value;
      OP_SHR:  nxt = shifted_dn | (sil ? top_bit : '0);
      OP_SHL: begin
        nxt    = shifted_up;
        nxt[0] = sir;
      end
      OP_LOAD: nxt = load_value;
      OP_ROR:  nxt = shifted_dn | (lsb ? top_bit : '0);
      OP_ROL: begin
        nxt    = shifted_up;
        nxt[0] = msb;
      end
      OP_ASR:  nxt = shifted_dn | (msb ? top_bit : '0);
      OP_CLR:  nxt = '0;
      default: nxt = value;
    endcase
    return nxt;
  endfunction

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_burst_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : usr_burst_ctrl                                                 |
// | Purpose : IDLE/BURST sequencer that repeats one shift/rotate op for a    |
// |           programmed number of clock edges.                              |
// | Ports   : clk, reset     - clock, asynchronous active-high reset         |
// |           ctrl           - op requested by the master this cycle         |
// |           burst_start    - request a burst of ctrl                       |
// |           burst_len      - number of steps, valid range 1..WIDTH         |
// |           op_eff         - op the datapath must execute at next edge     |
// |           busy           - registered, high while in BURST               |
// |           done           - registered one-cycle pulse after last step    |
// | Rev     : 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
module usr_burst_ctrl
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  usr_op_t          ctrl,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output usr_op_t          op_eff,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  usr_state_t       state;
  usr_state_t       next_state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] next_remaining;
  usr_op_t          op_latched;
  usr_op_t          next_op;
  logic             next_done;
  logic             accept;

  // A request that fails any check simply falls through as a single op.
  assign accept = (state == ST_IDLE) && burst_start &&
                  (burst_len != '0) && (burst_len <= MAX_LEN) &&
                  usr_burst_ok(ctrl);

  // Step 1 of a burst runs on the accept edge itself, so while idle the
  // datapath always follows ctrl; the latched op only matters in BURST.
  assign op_eff = (state == ST_BURST) ? op_latched : ctrl;

  always_comb begin
    next_state     = state;
    next_remaining = remaining;
    next_op        = op_latched;
    next_done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_op        = ctrl;
          next_remaining = burst_len - ONE;
          // A length-1 burst finishes on its accept edge.
          if (burst_len == ONE) next_done  = 1'b1;
          else                  next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        next_remaining = remaining - ONE;
        if (remaining == ONE) begin
          next_state = ST_IDLE;
          next_done  = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      remaining  <= '0;
      op_latched <= OP_HOLD;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= next_state;
      remaining  <= next_remaining;
      op_latched <= next_op;
      busy       <= (next_state == ST_BURST);
      done       <= next_done;
    end
  end

endmodule : usr_burst_ctrl
`default_nettype wire

// File: rtl/param_universal_shift_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : param_universal_shift_register                                 |
// | Purpose : WIDTH-bit universal shift register (hold, shift L/R, rotate    |
// |           L/R, arithmetic shift right, load, clear) with a burst engine  |
// |           that repeats a shift/rotate for up to WIDTH edges.             |
// | Params  : WIDTH - register width, 2..usr_pkg::USR_MAX_W                  |
// |           CNT_W - burst length width, derived from WIDTH                 |
// | Ports   : clk, reset          - clock, asynchronous active-high reset    |
// |           ctrl                - op select (usr_op_t encoding)            |
// |           serial_in_left      - bit entering the MSB on shift right      |
// |           serial_in_right     - bit entering the LSB on shift left       |
// |           parallel_in         - load value                               |
// |           burst_start         - request a burst of ctrl                  |
// |           burst_len           - burst step count, 1..WIDTH accepted      |
// |           out                 - register contents                        |
// |           serial_out_right    - out[0]                                   |
// |           serial_out_left     - out[WIDTH-1]                             |
// |           busy                - burst in progress, ctrl ignored          |
// |           done                - one-cycle pulse after final burst step   |
// | Rev     : 1.0  initial parametrised release                              |
// +--------------------------------------------------------------------------+
module param_universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       ctrl,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             burst_start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] out,
  output logic             serial_out_right,
  output logic             serial_out_left,
  output logic             busy,
  output logic             done
);

  usr_op_t          op_eff;
  logic [WIDTH-1:0] next_value;

  usr_burst_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_burst_ctrl (
    .clk         (clk),
    .reset       (reset),
    .ctrl        (usr_op_t'(ctrl)),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .op_eff      (op_eff),
    .busy        (busy),
    .done        (done)
  );

  // Operands are widened to the package width and the result narrowed back;
  // the function leaves everything above WIDTH at zero.
  assign next_value = WIDTH'(usr_next(op_eff,
                                      USR_MAX_W'(out),
                                      serial_in_left,
                                      serial_in_right,
                                      USR_MAX_W'(parallel_in),
                                      WIDTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= '0;
    else       out <= next_value;
  end

  assign serial_out_right = out[0];
  assign serial_out_left  = out[WIDTH-1];

endmodule : param_universal_shift_register
`default_nettype wire

// File: tb/tb_param_universal_shift_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_param_universal_shift_register                              |
// | Purpose : Self-checking bench for param_universal_shift_register, WIDTH=8|
// |           Directed scenarios with literal expectations, then random      |
// |           traffic against a queue-based reference model.                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_param_universal_shift_register;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ctrl = 3'b000;
  logic       sil = 1'b0;
  logic       sir = 1'b0;
  logic [7:0] pin = 8'h00;
  logic       bstart = 1'b0;
  logic [3:0] blen = 4'd0;
  logic [7:0] out;
  logic       sor;
  logic       sol;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  param_universal_shift_register #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl             (ctrl),
    .serial_in_left   (sil),
    .serial_in_right  (sir),
    .parallel_in      (pin),
    .burst_start      (bstart),
    .burst_len        (blen),
    .out              (out),
    .serial_out_right (sor),
    .serial_out_left  (sol),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // One op on an 8-bit value, written as plain arithmetic.
  function automatic logic [7:0] model_op(input logic [2:0] op, input logic [7:0] v,
                                          input logic l, input logic r,
                                          input logic [7:0] p);
    logic [7:0] res;
    case (op)
      3'd0: res = v;
      3'd1: res = (v >> 1) | (8'(l) << 7);
      3'd2: res = 8'((v << 1) | 8'(r));
      3'd3: res = p;
      3'd4: res = 8'((v >> 1) | (v << 7));
      3'd5: res = 8'((v << 1) | (v >> 7));
      3'd6: res = 8'($signed(v) >>> 1);
      default: res = 8'h00;
    endcase
    return res;
  endfunction

  logic [7:0] m_out  = 8'h00;
  logic       m_done = 1'b0;
  logic [2:0] pend[$];   // ops still owed by an accepted burst

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out  = 8'h00;
      m_done = 1'b0;
      pend.delete();
    end else begin
      m_done = 1'b0;
      if (pend.size() > 0) begin
        m_out = model_op(pend.pop_front(), m_out, sil, sir, pin);
        if (pend.size() == 0) m_done = 1'b1;
      end else if (bstart && blen >= 1 && blen <= WIDTH &&
                   (ctrl inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6})) begin
        m_out = model_op(ctrl, m_out, sil, sir, pin);
        for (int k = 1; k < int'(blen); k++) pend.push_back(ctrl);
        m_done = (blen == 4'd1);
      end else begin
        m_out = model_op(ctrl, m_out, sil, sir, pin);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    check("model.out",  32'(out),  32'(m_out));
    check("model.sor",  32'(sor),  32'(m_out[0]));
    check("model.sol",  32'(sol),  32'(m_out[7]));
    check("model.busy", 32'(busy), 32'(pend.size() > 0));
    check("model.done", 32'(done), 32'(m_done));
  end

  // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
  task automatic apply(input logic [2:0] c, input logic l, input logic r,
                       input logic [7:0] p, input logic bs, input logic [3:0] bl);
    ctrl = c; sil = l; sir = r; pin = p; bstart = bs; blen = bl;
    @(posedge clk);
    #1;
  endtask

  int done_count;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset.out",  32'(out),  32'h00);
    check("reset.busy", 32'(busy), 32'h0);
    check("reset.done", 32'(done), 32'h0);
    reset = 1'b0;

    // Reset asserted mid-cycle clears immediately.
    apply(3'd3, 0, 0, 8'hA5, 0, 0);
    check("load.a5", 32'(out), 32'hA5);
    #3 reset = 1'b1;
    #1;
    check("async_rst.out",  32'(out),  32'h00);
    check("async_rst.busy", 32'(busy), 32'h0);
    check("async_rst.done", 32'(done), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    apply(3'd0, 0, 0, 8'hFF, 0, 0);
    check("hold_after_rst", 32'(out), 32'h00);

    // Shift and hold.
    apply(3'd3, 0, 0, 8'hA5, 0, 0);
    apply(3'd1, 1, 0, 8'h00, 0, 0);
    check("shr.d2", 32'(out), 32'hD2);
    apply(3'd2, 0, 0, 8'h00, 0, 0);
    check("shl.a4", 32'(out), 32'hA4);
    apply(3'd0, 1, 1, 8'h00, 0, 0);
    check("hold.a4", 32'(out), 32'hA4);
    check("hold.sol", 32'(sol), 32'h1);
    check("hold.sor", 32'(sor), 32'h0);

    // Rotate, arithmetic shift, clear.
    apply(3'd3, 0, 0, 8'h81, 0, 0);
    apply(3'd4, 0, 0, 8'h00, 0, 0);
    check("ror.c0", 32'(out), 32'hC0);
    apply(3'd3, 0, 0, 8'h81, 0, 0);
    apply(3'd5, 0, 0, 8'h00, 0, 0);
    check("rol.03", 32'(out), 32'h03);
    apply(3'd3, 0, 0, 8'h90, 0, 0);
    apply(3'd6, 0, 0, 8'h00, 0, 0);
    check("asr.c8", 32'(out), 32'hC8);
    apply(3'd6, 0, 0, 8'h00, 0, 0);
    check("asr.e4", 32'(out), 32'hE4);
    apply(3'd7, 0, 0, 8'h00, 0, 0);
    check("clr.00", 32'(out), 32'h00);

    // Basic burst: rotate left 3 from 0x01; loads driven while busy are ignored.
    apply(3'd3, 0, 0, 8'h01, 0, 0);
    apply(3'd5, 0, 0, 8'h00, 1, 4'd3);
    check("burst3.s1", 32'(out), 32'h02);
    check("burst3.busy1", 32'(busy), 32'h1);
    apply(3'd3, 0, 0, 8'hFF, 0, 0);
    check("burst3.s2", 32'(out), 32'h04);
    check("burst3.busy2", 32'(busy), 32'h1);
    check("burst3.done2", 32'(done), 32'h0);
    apply(3'd3, 0, 0, 8'hFF, 0, 0);
    check("burst3.s3", 32'(out), 32'h08);
    check("burst3.busy3", 32'(busy), 32'h0);
    check("burst3.done3", 32'(done), 32'h1);
    apply(3'd0, 0, 0, 8'h00, 0, 0);
    check("burst3.after", 32'(out), 32'h08);
    check("burst3.done_off", 32'(done), 32'h0);

    // Full-width rotate burst returns the original value; restarts ignored.
    apply(3'd3, 0, 0, 8'hA5, 0, 0);
    apply(3'd4, 0, 0, 8'h00, 1, 4'd8);
    done_count = 0;
    for (int s = 2; s <= 8; s++) begin
      if (done) done_count++;
      apply(3'd2, 1, 1, 8'h33, 1, 4'd2);
    end
    if (done) done_count++;
    check("burst8.out", 32'(out), 32'hA5);
    check("burst8.done_last", 32'(done), 32'h1);
    check("burst8.done_count", 32'(done_count), 32'd1);

    // Length-1 burst: one step, done next cycle, never busy.
    apply(3'd3, 0, 0, 8'h01, 0, 0);
    apply(3'd2, 0, 1, 8'h00, 1, 4'd1);
    check("burst1.out", 32'(out), 32'h03);
    check("burst1.busy", 32'(busy), 32'h0);
    check("burst1.done", 32'(done), 32'h1);

    // Rejected requests act as single ops.
    apply(3'd2, 0, 0, 8'h00, 1, 4'd0);
    check("len0.out", 32'(out), 32'h06);
    check("len0.done", 32'(done), 32'h0);
    apply(3'd3, 0, 0, 8'h3C, 1, 4'd4);
    check("loadburst.out", 32'(out), 32'h3C);
    check("loadburst.busy", 32'(busy), 32'h0);
    apply(3'd1, 0, 0, 8'h00, 1, 4'd9);
    check("len9.out", 32'(out), 32'h1E);
    check("len9.busy", 32'(busy), 32'h0);
    check("len9.done", 32'(done), 32'h0);

    // Reset mid-burst at step 4, then a fresh burst.
    apply(3'd3, 0, 0, 8'h5A, 0, 0);
    apply(3'd5, 0, 0, 8'h00, 1, 4'd8);
    apply(3'd0, 0, 0, 8'h00, 0, 0);
    apply(3'd0, 0, 0, 8'h00, 0, 0);
    check("midrst.pre", 32'(out), 32'hD2);
    #3 reset = 1'b1;
    #1;
    check("midrst.out",  32'(out),  32'h00);
    check("midrst.busy", 32'(busy), 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    apply(3'd0, 0, 0, 8'h00, 0, 0);
    check("midrst.nodone", 32'(done), 32'h0);
    apply(3'd3, 0, 0, 8'h0F, 0, 0);
    apply(3'd2, 0, 1, 8'h00, 1, 4'd2);
    check("reburst.s1", 32'(out), 32'h1F);
    check("reburst.busy", 32'(busy), 32'h1);
    apply(3'd0, 0, 1, 8'h00, 0, 0);
    check("reburst.s2", 32'(out), 32'h3F);
    check("reburst.done", 32'(done), 32'h1);

    // Random traffic; the negedge process compares against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 149) == 0);
      apply(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 10)));
    end
    reset = 1'b0;
    apply(3'd0, 0, 0, 8'h00, 0, 0);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_param_universal_shift_register
`default_nettype wire
